// File: rtl/vam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vam_pkg
// Brief    : Shared widths and FSM state encoding for the VAM-16 multiplier.
// Revision : 1.0
// ============================================================================
package vam_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vam16_top.sv
`default_nettype none
// ============================================================================
// Module   : vam16_top
// Brief    : Wires vam_controller to the VAM-16 multiplier datapath.
// Revision : 1.0
// ============================================================================
module vam16_top
    import vam_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] result,
    output logic [7:0]        op_count,
    output logic [PROD_W-1:0] acked_product
);

    logic [OP_W-1:0]   w_dp_a;
    logic [OP_W-1:0]   w_dp_b;
    logic [PROD_W-1:0] w_dp_w;
    logic              w_ready;

    vam_controller #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .dp_w       (w_dp_w),
        .dp_a       (w_dp_a),
        .dp_b       (w_dp_b),
        .ready_flag (w_ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .op_count   (op_count)
    );

    vam_datapath u_dp (
        .clk           (clk),
        .rst           (rst),
        .a             (w_dp_a),
        .b             (w_dp_b),
        .ready         (w_ready),
        .product       (w_dp_w),
        .acked_product (acked_product)
    );

endmodule
`default_nettype wire

// File: rtl/vam_datapath.sv
`default_nettype none
// ============================================================================
// Module   : vam_datapath
// Brief    : Combinational 8x8 unsigned multiplier with a product shadow
//            register that is loaded while the controller raises ready.
// Revision : 1.0
// ============================================================================
module vam_datapath
    import vam_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic              ready,
    output logic [PROD_W-1:0] product,
    output logic [PROD_W-1:0] acked_product
);

    assign product = PROD_W'(a) * PROD_W'(b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acked_product <= '0;
        end else if (ready) begin
            acked_product <= product;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vam_controller.sv
`default_nettype none
// ============================================================================
// Module   : vam_controller
// Brief    : Sequences one multiply: latch operands, wait out the settle
//            window, capture the product and pulse done/ready for one cycle.
// Revision : 1.0
// ============================================================================
module vam_controller
    import vam_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    input  logic [PROD_W-1:0] dp_w,
    output logic [OP_W-1:0]   dp_a,
    output logic [OP_W-1:0]   dp_b,
    output logic              ready_flag,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] result,
    output logic [7:0]        op_count
);

    // Loaded on accept; the capture happens on the edge that finds it at zero.
    localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_capture;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_capture = (r_state == WAIT) && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        ready_flag  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                ready_flag  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_a     <= '0;
            dp_b     <= '0;
            r_cnt    <= '0;
            result   <= '0;
            op_count <= '0;
        end else begin
            if (w_accept) begin
                dp_a  <= op_a;
                dp_b  <= op_b;
                r_cnt <= C_SETTLE_LOAD;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                result   <= dp_w;
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vam_controller.sv
`default_nettype none
// Scoreboard bench for vam_controller: SETTLE_CYCLES=4 main instance plus a
// SETTLE_CYCLES=1 instance for the minimum settle window.
module tb_vam_controller;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start1 = 1'b0;
    logic [7:0]  op_a = '0, op_b = '0, op_a1 = '0, op_b1 = '0;
    logic [15:0] dp_w, dp_w1;
    logic [7:0]  dp_a, dp_b, dp_a1, dp_b1;
    logic        ready_flag, busy, done, ready_flag1, busy1, done1;
    logic [15:0] result, result1;
    logic [7:0]  op_count, op_count1;

    int checks = 0;
    int passes = 0;
    logic [15:0] sb[$];
    logic [15:0] sb1[$];

    always #5 clk = ~clk;

    // Behavioural multiplier datapath feeding each controller.
    assign dp_w  = 16'(dp_a)  * 16'(dp_b);
    assign dp_w1 = 16'(dp_a1) * 16'(dp_b1);

    vam_controller #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .dp_w(dp_w), .dp_a(dp_a), .dp_b(dp_b), .ready_flag(ready_flag),
        .busy(busy), .done(done), .result(result), .op_count(op_count)
    );

    vam_controller #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
        .dp_w(dp_w1), .dp_a(dp_a1), .dp_b(dp_b1), .ready_flag(ready_flag1),
        .busy(busy1), .done(done1), .result(result1), .op_count(op_count1)
    );

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        sb.delete(); sb1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge right after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        op_a = a; op_b = b; start = 1'b1;
        sb.push_back(16'(a) * 16'(b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output bit seen);
        lat = 0; seen = 1'b0;
        while (lat < budget && !seen) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int n = 0; n < 10; n++) begin
            checks++;
            if ({busy, done, ready_flag, dp_a, dp_b, result, op_count} !== 43'd0)
                $display("FAIL reset_idle cycle=%0d got busy=%b done=%b rdy=%b a=%h b=%h res=%h cnt=%0d want all 0",
                         n, busy, done, ready_flag, dp_a, dp_b, result, op_count);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        logic [15:0] exp;
        apply_reset();
        issue(8'h0C, 8'h0A);
        checks++;
        if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy);
        else passes++;
        for (int n = 0; n <= S + 2; n++) begin
            checks++;
            if ({done, ready_flag} !== {2{n == S}})
                $display("FAIL single_done n=%0d got done=%b rdy=%b want %b", n, done, ready_flag, n == S);
            else passes++;
            if (n == S) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
                checks++;
                if (result !== exp) $display("FAIL single_result got %h want %h", result, exp);
                else passes++;
            end
            @(negedge clk);
        end
        checks++;
        if (op_count !== 8'd1 || busy !== 1'b0)
            $display("FAIL single_count got cnt=%0d busy=%b want cnt=1 busy=0", op_count, busy);
        else passes++;
    endtask

    task automatic test_max();
        int lat; bit seen;
        logic [15:0] exp;
        logic [7:0] a_v [3] = '{8'hFF, 8'h00, 8'hFF};
        logic [7:0] b_v [3] = '{8'hFF, 8'hFF, 8'h01};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            issue(a_v[i], b_v[i]);
            wait_done(S + 4, lat, seen);
            checks++;
            if (!seen || lat != S) $display("FAIL max_latency op=%0d got seen=%b lat=%0d want lat=%0d", i, seen, lat, S);
            else passes++;
            exp = sb.pop_front();
            checks++;
            if (result !== exp) $display("FAIL max_result op=%0d got %h want %h", i, result, exp);
            else passes++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 16'h00FF || op_count !== 8'd3)
            $display("FAIL max_hold got res=%h cnt=%0d want res=00ff cnt=3", result, op_count);
        else passes++;
    endtask

    task automatic test_start_while_busy();
        int lat; bit seen;
        logic [15:0] exp;
        apply_reset();
        issue(8'h11, 8'h22);
        start = 1'b1; op_a = 8'h55; op_b = 8'h66;
        repeat (2) @(negedge clk);
        checks++;
        if (dp_a !== 8'h11 || dp_b !== 8'h22 || busy !== 1'b1)
            $display("FAIL busy_frozen got a=%h b=%h busy=%b want a=11 b=22 busy=1", dp_a, dp_b, busy);
        else passes++;
        start = 1'b0;
        wait_done(S + 4, lat, seen);
        exp = sb.pop_front();
        checks++;
        if (!seen || lat != S - 2 || result !== exp)
            $display("FAIL busy_result got seen=%b lat=%0d res=%h want lat=%0d res=%h", seen, lat, result, S - 2, exp);
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || op_count !== 8'd1 || result !== 16'h0242)
            $display("FAIL busy_after got busy=%b cnt=%0d res=%h want 0/1/0242", busy, op_count, result);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_v [3] = '{8'd3, 8'd7, 8'h80};
        logic [7:0] b_v [3] = '{8'd5, 8'd9, 8'd2};
        logic [15:0] exp;
        int cycle, last, ndone;
        apply_reset();
        op_a = a_v[0]; op_b = b_v[0]; start = 1'b1;
        sb.push_back(16'(a_v[0]) * 16'(b_v[0]));
        cycle = 0; last = 0; ndone = 0;
        while (ndone < 3 && cycle < 60) begin
            @(negedge clk);
            cycle++;
            if (done) begin
                exp = sb.pop_front();
                checks++;
                if (result !== exp) $display("FAIL b2b_result op=%0d got %h want %h", ndone, result, exp);
                else passes++;
                if (ndone > 0) begin
                    checks++;
                    if (cycle - last != S + 2) $display("FAIL b2b_spacing op=%0d got %0d want %0d", ndone, cycle - last, S + 2);
                    else passes++;
                end
                last = cycle;
                ndone++;
                if (ndone < 3) begin
                    op_a = a_v[ndone]; op_b = b_v[ndone];
                    sb.push_back(16'(a_v[ndone]) * 16'(b_v[ndone]));
                end else start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (ndone != 3 || op_count !== 8'd3 || result !== 16'h0100)
            $display("FAIL b2b_final got ops=%0d cnt=%0d res=%h want 3/3/0100", ndone, op_count, result);
        else passes++;
    endtask

    task automatic test_wrap();
        int lat; bit seen;
        logic [15:0] exp;
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            issue(8'($urandom), 8'($urandom));
            wait_done(S + 4, lat, seen);
            exp = sb.pop_front();
            checks++;
            if (!seen || result !== exp) begin
                if (bad < 5) $display("FAIL wrap_result op=%0d got seen=%b res=%h want %h", i, seen, result, exp);
                bad++;
            end else passes++;
            @(negedge clk);
            if (i == 254) begin
                checks++;
                if (op_count !== 8'd255) $display("FAIL wrap_255 got %0d want 255", op_count);
                else passes++;
            end
        end
        checks++;
        if (op_count !== 8'd0) $display("FAIL wrap_zero got %0d want 0", op_count);
        else passes++;
    endtask

    task automatic test_reset_mid_wait();
        int lat; bit seen;
        logic [15:0] exp;
        int pulses = 0;
        apply_reset();
        issue(8'h0C, 8'h0A);
        wait_done(S + 4, lat, seen);
        exp = sb.pop_front();
        @(negedge clk);
        checks++;
        if (!seen || op_count !== 8'd1 || result !== exp)
            $display("FAIL rstmid_pre got seen=%b cnt=%0d res=%h want 1/1/%h", seen, op_count, result, exp);
        else passes++;
        issue(8'h21, 8'h03);
        void'(sb.pop_back());
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, ready_flag, dp_a, dp_b, result, op_count} !== 43'd0)
            $display("FAIL rstmid_clear got busy=%b done=%b rdy=%b a=%h b=%h res=%h cnt=%0d want all 0",
                     busy, done, ready_flag, dp_a, dp_b, result, op_count);
        else passes++;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0 || op_count !== 8'd0)
            $display("FAIL rstmid_after got stray=%0d cnt=%0d want 0/0", pulses, op_count);
        else passes++;
    endtask

    task automatic test_settle_one();
        logic [15:0] exp;
        apply_reset();
        op_a1 = 8'h13; op_b1 = 8'h07; start1 = 1'b1;
        sb1.push_back(16'(op_a1) * 16'(op_b1));
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) $display("FAIL s1_wait got done=%b busy=%b want 0/1", done1, busy1);
        else passes++;
        @(negedge clk);
        exp = sb1.pop_front();
        checks++;
        if (done1 !== 1'b1 || ready_flag1 !== 1'b1 || result1 !== exp)
            $display("FAIL s1_done got done=%b rdy=%b res=%h want 1/1/%h", done1, ready_flag1, result1, exp);
        else passes++;
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || op_count1 !== 8'd1)
            $display("FAIL s1_after got done=%b busy=%b cnt=%0d want 0/0/1", done1, busy1, op_count1);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_max();
        test_start_while_busy();
        test_back_to_back();
        test_wrap();
        test_reset_mid_wait();
        test_settle_one();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
